// File: rtl/mano_pkg.sv
// ============================================================================
// mano_pkg -- shared constants for the Mano basic computer control path
// Revision: 1.0
// ============================================================================
`default_nettype none

package mano_pkg;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    localparam int OP_AND = 0;
    localparam int OP_ADD = 1;
    localparam int OP_LDA = 2;
    localparam int OP_STA = 3;
    localparam int OP_BUN = 4;
    localparam int OP_BSA = 5;
    localparam int OP_ISZ = 6;
    localparam int OP_REG = 7;

    localparam int RR_CLA = 3;
    localparam int RR_CMA = 2;
    localparam int RR_INC = 1;
    localparam int RR_HLT = 0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mano_sequence_counter.sv
// ============================================================================
// mano_sequence_counter -- SC register (clear/increment/hold) with one-hot decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module mano_sequence_counter #(
    parameter int SC_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [SC_WIDTH-1:0]      sc,
    output logic [2**SC_WIDTH-1:0]   t_dec
);

    logic [SC_WIDTH-1:0] sc_q;
    logic [SC_WIDTH-1:0] sc_d;

    // Clear dominates increment so "SC<-0" always ends an instruction.
    always_comb begin
        sc_d = sc_q;
        if (clr) begin
            sc_d = '0;
        end else if (inc) begin
            sc_d = sc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign sc = sc_q;

    always_comb begin
        t_dec        = '0;
        t_dec[sc_q]  = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/mano_control_sequencer.sv
// ============================================================================
// mano_control_sequencer -- timing/control unit: T states, micro-op strobes, run/halt
// Revision: 1.0
// ============================================================================
`default_nettype none

module mano_control_sequencer
    import mano_pkg::*;
#(
    parameter int SC_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              d,
    input  logic                    i_bit,
    input  logic [3:0]              addr,
    input  logic                    dr_zero,
    output logic [2**SC_WIDTH-1:0]  t,
    output logic                    halted,
    output logic                    ar_ld_pc,
    output logic                    pc_inc,
    output logic                    ar_ld_mem,
    output logic                    ar_inc,
    output logic                    dr_ld_mem,
    output logic                    dr_inc,
    output logic                    ac_and,
    output logic                    ac_add,
    output logic                    ac_ld_dr,
    output logic                    mem_wr_ac,
    output logic                    mem_wr_pc,
    output logic                    mem_wr_dr,
    output logic                    pc_ld_ar,
    output logic                    ac_clr,
    output logic                    ac_cmp,
    output logic                    ac_inc
);

    run_state_t                state_q;
    run_state_t                state_d;
    logic [SC_WIDTH-1:0]       w_sc;
    logic [2**SC_WIDTH-1:0]    w_t_dec;
    logic                      w_sc_clr;
    logic                      w_sc_inc;
    logic [7:0]                w_op;

    mano_sequence_counter #(
        .SC_WIDTH (SC_WIDTH)
    ) u_sc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_sc_clr),
        .inc   (w_sc_inc),
        .sc    (w_sc),
        .t_dec (w_t_dec)
    );

    // A malformed opcode collapses to zero so it decodes as a no-op everywhere.
    assign w_op   = is_onehot8(d) ? d : 8'h00;
    assign halted = (state_q == ST_HALT);
    assign t      = halted ? '0 : w_t_dec;

    always_comb begin
        state_d   = state_q;
        w_sc_clr  = 1'b0;
        w_sc_inc  = 1'b0;
        ar_ld_pc  = 1'b0;
        pc_inc    = 1'b0;
        ar_ld_mem = 1'b0;
        ar_inc    = 1'b0;
        dr_ld_mem = 1'b0;
        dr_inc    = 1'b0;
        ac_and    = 1'b0;
        ac_add    = 1'b0;
        ac_ld_dr  = 1'b0;
        mem_wr_ac = 1'b0;
        mem_wr_pc = 1'b0;
        mem_wr_dr = 1'b0;
        pc_ld_ar  = 1'b0;
        ac_clr    = 1'b0;
        ac_cmp    = 1'b0;
        ac_inc    = 1'b0;

        if (state_q == ST_HALT) begin
            w_sc_clr = 1'b1;
            if (start) begin
                state_d = ST_RUN;
            end
        end else begin
            w_sc_inc = 1'b1;
            case (w_sc)
                SC_WIDTH'(T0): ar_ld_pc = 1'b1;
                SC_WIDTH'(T1): pc_inc   = 1'b1;
                SC_WIDTH'(T2): ;
                SC_WIDTH'(T3): begin
                    if (w_op == 8'h00 || w_op[OP_REG]) begin
                        w_sc_clr = 1'b1;
                    end
                    if (w_op[OP_REG] && !i_bit) begin
                        ac_clr = addr[RR_CLA];
                        ac_cmp = addr[RR_CMA];
                        ac_inc = addr[RR_INC];
                        if (addr[RR_HLT]) begin
                            state_d = ST_HALT;
                        end
                    end else if (w_op != 8'h00 && !w_op[OP_REG]) begin
                        ar_ld_mem = i_bit;
                    end
                end
                SC_WIDTH'(T4): begin
                    dr_ld_mem = w_op[OP_AND] | w_op[OP_ADD] | w_op[OP_LDA] | w_op[OP_ISZ];
                    mem_wr_ac = w_op[OP_STA];
                    pc_ld_ar  = w_op[OP_BUN];
                    mem_wr_pc = w_op[OP_BSA];
                    ar_inc    = w_op[OP_BSA];
                    w_sc_clr  = !(dr_ld_mem | w_op[OP_BSA]);
                end
                SC_WIDTH'(T5): begin
                    ac_and   = w_op[OP_AND];
                    ac_add   = w_op[OP_ADD];
                    ac_ld_dr = w_op[OP_LDA];
                    pc_ld_ar = w_op[OP_BSA];
                    dr_inc   = w_op[OP_ISZ];
                    w_sc_clr = !w_op[OP_ISZ];
                end
                SC_WIDTH'(T6): begin
                    mem_wr_dr = w_op[OP_ISZ];
                    pc_inc    = w_op[OP_ISZ] & dr_zero;
                    w_sc_clr  = 1'b1;
                end
                // T7 and any wider unused count are dead states: recover to T0.
                default: w_sc_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mano_control_sequencer.sv
// ============================================================================
// tb_mano_control_sequencer -- scoreboard bench for the Mano control sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mano_control_sequencer;

    localparam int S_AR_LD_PC  = 0;
    localparam int S_PC_INC    = 1;
    localparam int S_AR_LD_MEM = 2;
    localparam int S_AR_INC    = 3;
    localparam int S_DR_LD_MEM = 4;
    localparam int S_DR_INC    = 5;
    localparam int S_AC_AND    = 6;
    localparam int S_AC_ADD    = 7;
    localparam int S_AC_LD_DR  = 8;
    localparam int S_MEM_WR_AC = 9;
    localparam int S_MEM_WR_PC = 10;
    localparam int S_MEM_WR_DR = 11;
    localparam int S_PC_LD_AR  = 12;
    localparam int S_AC_CLR    = 13;
    localparam int S_AC_CMP    = 14;
    localparam int S_AC_INC    = 15;

    localparam logic [24:0] HALT_VEC = {1'b1, 8'h00, 16'h0000};

    typedef struct packed {
        logic        st;
        logic [7:0]  d;
        logic        ib;
        logic [3:0]  a;
        logic        dz;
        logic [24:0] exp;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  d;
    logic        i_bit;
    logic [3:0]  addr;
    logic        dr_zero;
    logic [7:0]  t;
    logic        halted;
    logic ar_ld_pc, pc_inc, ar_ld_mem, ar_inc, dr_ld_mem, dr_inc, ac_and, ac_add;
    logic ac_ld_dr, mem_wr_ac, mem_wr_pc, mem_wr_dr, pc_ld_ar, ac_clr, ac_cmp, ac_inc;

    logic [15:0] stb;
    logic [24:0] obs;
    ent_t        q[$];
    ent_t        e;
    int          n_checks;
    int          n_pass;

    mano_control_sequencer #(.SC_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .d(d), .i_bit(i_bit), .addr(addr),
        .dr_zero(dr_zero), .t(t), .halted(halted),
        .ar_ld_pc(ar_ld_pc), .pc_inc(pc_inc), .ar_ld_mem(ar_ld_mem), .ar_inc(ar_inc),
        .dr_ld_mem(dr_ld_mem), .dr_inc(dr_inc), .ac_and(ac_and), .ac_add(ac_add),
        .ac_ld_dr(ac_ld_dr), .mem_wr_ac(mem_wr_ac), .mem_wr_pc(mem_wr_pc),
        .mem_wr_dr(mem_wr_dr), .pc_ld_ar(pc_ld_ar), .ac_clr(ac_clr), .ac_cmp(ac_cmp),
        .ac_inc(ac_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stb = {ac_inc, ac_cmp, ac_clr, pc_ld_ar, mem_wr_dr, mem_wr_pc, mem_wr_ac,
                  ac_ld_dr, ac_add, ac_and, dr_inc, dr_ld_mem, ar_inc, ar_ld_mem,
                  pc_inc, ar_ld_pc};
    assign obs = {halted, t, stb};

    task automatic push_halted(input int n, input logic st_v);
        ent_t x;
        for (int k = 0; k < n; k++) begin
            x = '{st: st_v, d: 8'h00, ib: 1'b0, a: 4'h0, dz: 1'b0, exp: HALT_VEC};
            q.push_back(x);
        end
    endtask

    // Expected per-cycle strobes for one instruction, from T0 through its last state.
    task automatic push_instr(input logic [7:0] dv, input logic iv, input logic [3:0] av,
                              input logic dz);
        logic [15:0] s [7];
        int          len;
        ent_t        x;
        for (int k = 0; k < 7; k++) s[k] = 16'h0;
        s[0][S_AR_LD_PC] = 1'b1;
        s[1][S_PC_INC]   = 1'b1;
        len = 4;
        if (dv == 8'h80) begin
            if (!iv) begin
                s[3][S_AC_CLR] = av[3];
                s[3][S_AC_CMP] = av[2];
                s[3][S_AC_INC] = av[1];
            end
        end else if (dv inside {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40}) begin
            s[3][S_AR_LD_MEM] = iv;
            case (dv)
                8'h01: begin s[4][S_DR_LD_MEM] = 1'b1; s[5][S_AC_AND] = 1'b1; len = 6; end
                8'h02: begin s[4][S_DR_LD_MEM] = 1'b1; s[5][S_AC_ADD] = 1'b1; len = 6; end
                8'h04: begin s[4][S_DR_LD_MEM] = 1'b1; s[5][S_AC_LD_DR] = 1'b1; len = 6; end
                8'h08: begin s[4][S_MEM_WR_AC] = 1'b1; len = 5; end
                8'h10: begin s[4][S_PC_LD_AR] = 1'b1; len = 5; end
                8'h20: begin
                    s[4][S_MEM_WR_PC] = 1'b1;
                    s[4][S_AR_INC]    = 1'b1;
                    s[5][S_PC_LD_AR]  = 1'b1;
                    len = 6;
                end
                default: begin
                    s[4][S_DR_LD_MEM] = 1'b1;
                    s[5][S_DR_INC]    = 1'b1;
                    s[6][S_MEM_WR_DR] = 1'b1;
                    s[6][S_PC_INC]    = dz;
                    len = 7;
                end
            endcase
        end
        for (int k = 0; k < len; k++) begin
            x = '{st: 1'b0, d: dv, ib: iv, a: av, dz: dz,
                  exp: {1'b0, 8'(1 << k), s[k]}};
            q.push_back(x);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; d = 8'h00; i_bit = 1'b0; addr = 4'h0; dr_zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs !== HALT_VEC) $display("FAIL reset_hold got=%h exp=%h", obs, HALT_VEC);
            else n_pass++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        push_halted(10, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL reset_idle got=%h exp=%h", obs, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_start_invalid();
        push_halted(1, 1'b1);
        push_instr(8'h00, 1'b0, 4'h0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL start_invalid got=%h exp=%h", obs, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_add_isz_bsa();
        push_instr(8'h02, 1'b0, 4'h0, 1'b0);
        push_instr(8'h40, 1'b0, 4'h0, 1'b1);
        push_instr(8'h40, 1'b0, 4'h0, 1'b0);
        push_instr(8'h20, 1'b1, 4'h0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL add_isz_bsa d=%h got=%h exp=%h", e.d, obs, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        push_instr(8'h01, 1'b1, 4'h0, 1'b0);
        push_instr(8'h04, 1'b0, 4'h0, 1'b0);
        push_instr(8'h08, 1'b1, 4'h0, 1'b0);
        push_instr(8'h10, 1'b0, 4'h0, 1'b0);
        push_instr(8'h80, 1'b1, 4'hF, 1'b0);
        push_instr(8'h03, 1'b0, 4'h0, 1'b0);
        push_instr(8'h80, 1'b0, 4'h4, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL back_to_back d=%h got=%h exp=%h", e.d, obs, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        int base;
        push_instr(8'h80, 1'b0, 4'b1011, 1'b0);
        q[q.size()-1].st = 1'b1;   // start coincident with HLT at T3: halt must win
        push_halted(3, 1'b0);
        push_halted(1, 1'b1);
        base = q.size();
        push_instr(8'h08, 1'b0, 4'h0, 1'b0);
        q[base+1].st = 1'b1;       // start while running is ignored
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL halt d=%h got=%h exp=%h", e.d, obs, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        push_instr(8'h04, 1'b0, 4'h0, 1'b0);
        repeat (5) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL lda_pre_reset got=%h exp=%h", obs, e.exp);
            else n_pass++;
        end
        q.delete();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== HALT_VEC) $display("FAIL reset_async got=%h exp=%h", obs, HALT_VEC);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== HALT_VEC) $display("FAIL reset_after got=%h exp=%h", obs, HALT_VEC);
        else n_pass++;
        push_halted(1, 1'b1);
        push_instr(8'h00, 1'b0, 4'h0, 1'b0);
        push_instr(8'h02, 1'b0, 4'h0, 1'b0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            start = e.st; d = e.d; i_bit = e.ib; addr = e.a; dr_zero = e.dz;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) $display("FAIL post_reset d=%h got=%h exp=%h", e.d, obs, e.exp);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_start_invalid();
        test_add_isz_bsa();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
